// File: rtl/fft_twiddle_mult_seq.sv
// fft_twiddle_mult_seq
// Complex twiddle multiplier for R22SDF FFT stages, z = x * w, built on the
// three-multiply Karatsuba form:
//   f = w_re*(x_re - x_im)
//   R = x_im*(w_re - w_im) + f
//   I = x_re*(w_re + w_im) - f
// R and I are kept at full precision, scaled down by 2^(TWIDDLE_WIDTH-1),
// then saturated to DATA_WIDTH bits. ovf_o flags a clipped component.
//
// SHARE = 1 : three parallel multipliers, one sample per cycle, latency 3.
// SHARE = 3 : one shared multiply-add sequenced by a small FSM
//             (S_IDLE -> S_F -> S_R -> S_I), one sample per 3 cycles,
//             latency 4. Any other SHARE value is unsupported.
//
// Build option: define FFT_TWIDDLE_MULT_ROUND_EN for round-half-up scaling;
// without it the scaling truncates toward -inf. Timing is identical.
//
// Ports
//   clk_i             clock
//   rst_n             synchronous active-low reset
//   valid_i/ready_o   input handshake, sample taken on valid_i & ready_o
//   ctr_i             FFT index carried alongside the sample
//   x_re_i/x_im_i     data in (signed, DATA_WIDTH)
//   w_re_i/w_im_i     twiddle in (signed, TWIDDLE_WIDTH, 2^(TW-1) == 1.0)
//   valid_o           one-cycle output strobe, no backpressure
//   ctr_o             ctr_i of the sample on z_*_o
//   z_re_o/z_im_o     product out (signed, DATA_WIDTH)
//   ovf_o             saturation flag, qualified by valid_o
module fft_twiddle_mult_seq #(
  parameter int DATA_WIDTH    = 25,
  parameter int TWIDDLE_WIDTH = 10,
  parameter int NLOG2         = 10,
  parameter int SHARE         = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [NLOG2-1:0]         ctr_i,
  input  logic [DATA_WIDTH-1:0]    x_re_i,
  input  logic [DATA_WIDTH-1:0]    x_im_i,
  input  logic [TWIDDLE_WIDTH-1:0] w_re_i,
  input  logic [TWIDDLE_WIDTH-1:0] w_im_i,
  output logic                     valid_o,
  output logic [NLOG2-1:0]         ctr_o,
  output logic [DATA_WIDTH-1:0]    z_re_o,
  output logic [DATA_WIDTH-1:0]    z_im_o,
  output logic                     ovf_o
);

  localparam int DW = DATA_WIDTH;
  localparam int TW = TWIDDLE_WIDTH;
  localparam int P  = DW + TW + 2;

  localparam logic signed [P-1:0] Z_MAX = {{(P-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [P-1:0] Z_MIN = {{(P-DW+1){1'b1}}, {(DW-1){1'b0}}};

`ifdef FFT_TWIDDLE_MULT_ROUND_EN
  localparam logic signed [P-1:0] RND_HALF = {{(P-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};
`endif

  // Drop the Q(TW-1) fraction of the twiddle. Magnitudes stay below 2^(P-2),
  // so the rounding offset cannot wrap.
  function automatic logic signed [P-1:0] scale(input logic signed [P-1:0] v);
`ifdef FFT_TWIDDLE_MULT_ROUND_EN
    return (v + RND_HALF) >>> (TW-1);
`else
    return v >>> (TW-1);
`endif
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [P-1:0] v);
    if (v > Z_MAX) return Z_MAX[DW-1:0];
    if (v < Z_MIN) return Z_MIN[DW-1:0];
    return v[DW-1:0];
  endfunction

  function automatic logic clips(input logic signed [P-1:0] v);
    return (v > Z_MAX) || (v < Z_MIN);
  endfunction

  logic                 rdy;
  logic                 accept;
  logic signed [DW-1:0] x_re_p0, x_im_p0;
  logic signed [TW-1:0] w_re_p0, w_im_p0;
  logic [NLOG2-1:0]     ctr_p0;

  logic                 vld_p2;
  logic signed [P-1:0]  r_p2, i_p2;
  logic [NLOG2-1:0]     ctr_p2;

  logic signed [DW:0]   xd, xr_e, xi_e;
  logic signed [TW:0]   wr_e, wd, ws;
  logic signed [P-1:0]  r_sc, i_sc;

  assign ready_o = rdy;
  assign accept  = valid_i & rdy;

  // ---- stage p0: operand capture ----
  always_ff @(posedge clk_i) begin
    if (accept) begin
      x_re_p0 <= x_re_i;
      x_im_p0 <= x_im_i;
      w_re_p0 <= w_re_i;
      w_im_p0 <= w_im_i;
      ctr_p0  <= ctr_i;
    end
  end

  always_comb begin
    xr_e = {x_re_p0[DW-1], x_re_p0};
    xi_e = {x_im_p0[DW-1], x_im_p0};
    xd   = {x_re_p0[DW-1], x_re_p0} - {x_im_p0[DW-1], x_im_p0};
    wr_e = {w_re_p0[TW-1], w_re_p0};
    wd   = {w_re_p0[TW-1], w_re_p0} - {w_im_p0[TW-1], w_im_p0};
    ws   = {w_re_p0[TW-1], w_re_p0} + {w_im_p0[TW-1], w_im_p0};
  end

  if (SHARE == 1) begin : g_par
    logic                vld_p0, vld_p1;
    logic signed [P-1:0] f_p1, m_re_p1, m_im_p1;
    logic [NLOG2-1:0]    ctr_p1;

    assign rdy = 1'b1;

    always_ff @(posedge clk_i) begin
      if (!rst_n) begin
        vld_p0 <= 1'b0;
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        vld_p0 <= accept;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
      end
    end

    // ---- stage p1: the three partial products ----
    always_ff @(posedge clk_i) begin
      f_p1    <= P'(xd)   * P'(wr_e);
      m_re_p1 <= P'(xi_e) * P'(wd);
      m_im_p1 <= P'(xr_e) * P'(ws);
      ctr_p1  <= ctr_p0;
    end

    // ---- stage p2: Karatsuba recombination ----
    always_ff @(posedge clk_i) begin
      r_p2   <= m_re_p1 + f_p1;
      i_p2   <= m_im_p1 - f_p1;
      ctr_p2 <= ctr_p1;
    end
  end else begin : g_seq
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_F    = 2'd1;
    localparam logic [1:0] S_R    = 2'd2;
    localparam logic [1:0] S_I    = 2'd3;

    logic [1:0]          state;
    logic signed [P-1:0] mul_a, mul_b, prod;
    logic signed [P-1:0] f_p1;

    // S_I also accepts: the next sample lands in the operand registers on the
    // same edge that I is taken from the old operands.
    assign rdy = (state == S_IDLE) || (state == S_I);

    always_comb begin
      mul_a = P'(xd);
      mul_b = P'(wr_e);
      case (state)
        S_R: begin
          mul_a = P'(xi_e);
          mul_b = P'(wd);
        end
        S_I: begin
          mul_a = P'(xr_e);
          mul_b = P'(ws);
        end
        default: ;
      endcase
      prod = mul_a * mul_b;
    end

    always_ff @(posedge clk_i) begin
      if (!rst_n) begin
        state  <= S_IDLE;
        vld_p2 <= 1'b0;
      end else begin
        vld_p2 <= (state == S_I);
        case (state)
          S_IDLE:  if (valid_i) state <= S_F;
          S_F:     state <= S_R;
          S_R:     state <= S_I;
          S_I:     state <= valid_i ? S_F : S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end

    // ---- stage p1/p2: shared multiply-add, one term per state ----
    always_ff @(posedge clk_i) begin
      case (state)
        S_F: f_p1 <= prod;
        S_R: r_p2 <= prod + f_p1;
        S_I: begin
          i_p2   <= prod - f_p1;
          ctr_p2 <= ctr_p0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    r_sc = scale(r_p2);
    i_sc = scale(i_p2);
  end

  // ---- stage p3: scaled, saturated output register ----
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      ctr_o   <= '0;
      z_re_o  <= '0;
      z_im_o  <= '0;
      ovf_o   <= 1'b0;
    end else begin
      valid_o <= vld_p2;
      if (vld_p2) begin
        ctr_o  <= ctr_p2;
        z_re_o <= sat(r_sc);
        z_im_o <= sat(i_sc);
        ovf_o  <= clips(r_sc) | clips(i_sc);
      end
    end
  end

endmodule

// File: tb/tb_fft_twiddle_mult_seq.sv
// Self-checking bench for fft_twiddle_mult_seq. Two instances are exercised
// in turn: unit 0 with SHARE=1 and unit 1 with SHARE=3.
module tb_fft_twiddle_mult_seq;
  localparam int DW = 25;
  localparam int TW = 10;
  localparam int NL = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rstn_s  [2];
  logic                 valid_s [2];
  logic                 ready_s [2];
  logic [NL-1:0]        ctr_s   [2];
  logic signed [DW-1:0] xre_s   [2];
  logic signed [DW-1:0] xim_s   [2];
  logic signed [TW-1:0] wre_s   [2];
  logic signed [TW-1:0] wim_s   [2];
  logic                 vo_s    [2];
  logic [NL-1:0]        ctro_s  [2];
  logic signed [DW-1:0] zre_s   [2];
  logic signed [DW-1:0] zim_s   [2];
  logic                 ovf_s   [2];

  int n_checks = 0;
  int n_fail   = 0;

  fft_twiddle_mult_seq #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .NLOG2(NL), .SHARE(1)) dut_par (
    .clk_i(clk), .rst_n(rstn_s[0]), .valid_i(valid_s[0]), .ready_o(ready_s[0]),
    .ctr_i(ctr_s[0]), .x_re_i(xre_s[0]), .x_im_i(xim_s[0]), .w_re_i(wre_s[0]), .w_im_i(wim_s[0]),
    .valid_o(vo_s[0]), .ctr_o(ctro_s[0]), .z_re_o(zre_s[0]), .z_im_o(zim_s[0]), .ovf_o(ovf_s[0])
  );

  fft_twiddle_mult_seq #(.DATA_WIDTH(DW), .TWIDDLE_WIDTH(TW), .NLOG2(NL), .SHARE(3)) dut_seq (
    .clk_i(clk), .rst_n(rstn_s[1]), .valid_i(valid_s[1]), .ready_o(ready_s[1]),
    .ctr_i(ctr_s[1]), .x_re_i(xre_s[1]), .x_im_i(xim_s[1]), .w_re_i(wre_s[1]), .w_im_i(wim_s[1]),
    .valid_o(vo_s[1]), .ctr_o(ctro_s[1]), .z_re_o(zre_s[1]), .z_im_o(zim_s[1]), .ovf_o(ovf_s[1])
  );

  // Reference: direct complex product (four multiplies), shift, clamp.
  function automatic void golden(input logic signed [DW-1:0] a_re, input logic signed [DW-1:0] a_im,
                                 input logic signed [TW-1:0] b_re, input logic signed [TW-1:0] b_im,
                                 output logic signed [DW-1:0] g_re, output logic signed [DW-1:0] g_im,
                                 output logic g_ovf);
    longint r, i, hi, lo;
    logic ov_r, ov_i;
    hi = (longint'(1) <<< (DW-1)) - 1;
    lo = -hi - 1;
    r = longint'(a_re) * longint'(b_re) - longint'(a_im) * longint'(b_im);
    i = longint'(a_re) * longint'(b_im) + longint'(a_im) * longint'(b_re);
`ifdef FFT_TWIDDLE_MULT_ROUND_EN
    r = r + (longint'(1) <<< (TW-2));
    i = i + (longint'(1) <<< (TW-2));
`endif
    r = r >>> (TW-1);
    i = i >>> (TW-1);
    ov_r = (r > hi) || (r < lo);
    ov_i = (i > hi) || (i < lo);
    if (r > hi) r = hi; else if (r < lo) r = lo;
    if (i > hi) i = hi; else if (i < lo) i = lo;
    g_re  = r[DW-1:0];
    g_im  = i[DW-1:0];
    g_ovf = ov_r | ov_i;
  endfunction

  // Drives one sample and returns the first output plus its latency in edges
  // counted from the accept edge (-1 if none appeared).
  task automatic send_and_capture(input int u, input logic [NL-1:0] c,
                                  input logic signed [DW-1:0] a_re, input logic signed [DW-1:0] a_im,
                                  input logic signed [TW-1:0] b_re, input logic signed [TW-1:0] b_im,
                                  output logic signed [DW-1:0] o_re, output logic signed [DW-1:0] o_im,
                                  output logic o_ovf, output logic [NL-1:0] o_ctr, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (ready_s[u] !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    valid_s[u] = 1'b1;
    ctr_s[u] = c;
    xre_s[u] = a_re;
    xim_s[u] = a_im;
    wre_s[u] = b_re;
    wim_s[u] = b_im;
    @(posedge clk);
    @(negedge clk);
    valid_s[u] = 1'b0;
    lat = -1;
    o_re = '0;
    o_im = '0;
    o_ovf = 1'b0;
    o_ctr = '0;
    for (int k = 0; k <= 10; k++) begin
      if (vo_s[u] === 1'b1) begin
        lat = k;
        o_re = zre_s[u];
        o_im = zim_s[u];
        o_ovf = ovf_s[u];
        o_ctr = ctro_s[u];
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset(input int u);
    @(negedge clk);
    rstn_s[u] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn_s[u] = 1'b1;
    n_checks++;
    if (ready_s[u] !== 1'b1 || vo_s[u] !== 1'b0 || ovf_s[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl u%0d: ready=%b valid=%b ovf=%b, want 1 0 0", u, ready_s[u], vo_s[u], ovf_s[u]);
    end
    n_checks++;
    if (zre_s[u] !== '0 || zim_s[u] !== '0 || ctro_s[u] !== '0) begin
      n_fail++;
      $display("FAIL reset_data u%0d: z=(%0d,%0d) ctr=%0d, want 0", u, zre_s[u], zim_s[u], ctro_s[u]);
    end
  endtask

  task automatic test_basic(input int u);
    logic signed [DW-1:0] r, i;
    logic o;
    logic [NL-1:0] c;
    int lat;
    send_and_capture(u, 10'h2A5, 25'sd1000, 25'sd0, 10'sd256, 10'sd256, r, i, o, c, lat);
    n_checks++;
    if (lat !== ((u == 0) ? 3 : 4)) begin
      n_fail++;
      $display("FAIL basic_latency u%0d: got %0d want %0d", u, lat, (u == 0) ? 3 : 4);
    end
    n_checks++;
    if (r !== 25'sd500 || i !== 25'sd500 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_z u%0d: got (%0d,%0d) ovf=%b want (500,500) ovf=0", u, r, i, o);
    end
    n_checks++;
    if (c !== 10'h2A5) begin
      n_fail++;
      $display("FAIL basic_ctr u%0d: got %h want 2a5", u, c);
    end
    @(negedge clk);
    n_checks++;
    if (vo_s[u] !== 1'b0 || zre_s[u] !== 25'sd500 || ctro_s[u] !== 10'h2A5) begin
      n_fail++;
      $display("FAIL basic_hold u%0d: valid=%b z_re=%0d ctr=%h want 0 500 2a5", u, vo_s[u], zre_s[u], ctro_s[u]);
    end
  endtask

  task automatic test_rounding(input int u);
    logic signed [DW-1:0] r, i, er;
    logic o;
    logic [NL-1:0] c;
    int lat;
`ifdef FFT_TWIDDLE_MULT_ROUND_EN
    er = 25'sd2;
`else
    er = 25'sd1;
`endif
    send_and_capture(u, 10'd1, 25'sd3, 25'sd0, 10'sd256, 10'sd0, r, i, o, c, lat);
    n_checks++;
    if (r !== er || i !== 25'sd0 || o !== 1'b0 || lat < 0) begin
      n_fail++;
      $display("FAIL round_pos u%0d: got (%0d,%0d) ovf=%b lat=%0d want (%0d,0) ovf=0", u, r, i, o, lat, er);
    end
`ifdef FFT_TWIDDLE_MULT_ROUND_EN
    er = -25'sd1;
`else
    er = -25'sd2;
`endif
    send_and_capture(u, 10'd2, -25'sd3, 25'sd0, 10'sd256, 10'sd0, r, i, o, c, lat);
    n_checks++;
    if (r !== er || i !== 25'sd0 || o !== 1'b0 || lat < 0) begin
      n_fail++;
      $display("FAIL round_neg u%0d: got (%0d,%0d) ovf=%b lat=%0d want (%0d,0) ovf=0", u, r, i, o, lat, er);
    end
  endtask

  task automatic test_saturation(input int u);
    logic signed [DW-1:0] r, i;
    logic o;
    logic [NL-1:0] c;
    int lat;
    send_and_capture(u, 10'd3, 25'sh1000000, 25'sh1000000, 10'sh200, 10'sd0, r, i, o, c, lat);
    n_checks++;
    if (r !== 25'sh0FFFFFF || i !== 25'sh0FFFFFF || lat < 0) begin
      n_fail++;
      $display("FAIL sat_z u%0d: got (%0d,%0d) want (16777215,16777215)", u, r, i);
    end
    n_checks++;
    if (o !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_ovf u%0d: got %b want 1", u, o);
    end
    send_and_capture(u, 10'd4, 25'sd100, -25'sd200, 10'sh200, 10'sd0, r, i, o, c, lat);
    n_checks++;
    if (r !== -25'sd100 || i !== 25'sd200 || o !== 1'b0 || c !== 10'd4) begin
      n_fail++;
      $display("FAIL minus_one u%0d: got (%0d,%0d) ovf=%b ctr=%0d want (-100,200) ovf=0 ctr=4", u, r, i, o, c);
    end
  endtask

  task automatic test_back_to_back(input int u);
    logic [NL-1:0] q[$];
    logic [11:0] rdy_pat, rdy_exp;
    int nexp, step;
    nexp = (u == 0) ? 12 : 4;
    step = (u == 0) ? 1 : 3;
    rdy_exp = (u == 0) ? 12'hFFF : 12'h249;
    rdy_pat = '0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (vo_s[u] === 1'b1) q.push_back(ctro_s[u]);
      if (c < 12) begin
        valid_s[u] = 1'b1;
        ctr_s[u] = NL'(c);
        xre_s[u] = 25'sd1000;
        xim_s[u] = 25'sd0;
        wre_s[u] = 10'sd256;
        wim_s[u] = 10'sd256;
        rdy_pat[c] = ready_s[u];
      end else begin
        valid_s[u] = 1'b0;
      end
    end
    n_checks++;
    if (rdy_pat !== rdy_exp) begin
      n_fail++;
      $display("FAIL b2b_ready u%0d: got %b want %b", u, rdy_pat, rdy_exp);
    end
    n_checks++;
    if (q.size() != nexp) begin
      n_fail++;
      $display("FAIL b2b_count u%0d: got %0d want %0d", u, q.size(), nexp);
    end
    for (int k = 0; k < q.size(); k++) begin
      n_checks++;
      if (q[k] !== NL'(k * step)) begin
        n_fail++;
        $display("FAIL b2b_ctr u%0d idx %0d: got %0d want %0d", u, k, q[k], k * step);
      end
    end
  endtask

  task automatic test_reset_midop(input int u);
    int seen;
    @(negedge clk);
    valid_s[u] = 1'b1;
    ctr_s[u] = 10'd7;
    xre_s[u] = 25'sd1000;
    xim_s[u] = 25'sd0;
    wre_s[u] = 10'sd256;
    wim_s[u] = 10'sd256;
    @(posedge clk);
    @(negedge clk);
    valid_s[u] = 1'b0;
    @(negedge clk);
    rstn_s[u] = 1'b0;
    @(negedge clk);
    rstn_s[u] = 1'b1;
    n_checks++;
    if (ready_s[u] !== 1'b1 || vo_s[u] !== 1'b0 || zre_s[u] !== '0 || zim_s[u] !== '0 ||
        ctro_s[u] !== '0 || ovf_s[u] !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state u%0d: ready=%b valid=%b z=(%0d,%0d) ctr=%0d ovf=%b want 1 0 (0,0) 0 0",
               u, ready_s[u], vo_s[u], zre_s[u], zim_s[u], ctro_s[u], ovf_s[u]);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (vo_s[u] === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midreset_novalid u%0d: got %0d outputs want 0", u, seen);
    end
  endtask

  task automatic new_sample(input int u, input int idx);
    valid_s[u] = ($urandom_range(0, 3) != 0);
    ctr_s[u] = NL'(idx);
    xre_s[u] = DW'($urandom);
    xim_s[u] = DW'($urandom);
    wre_s[u] = TW'($urandom);
    wim_s[u] = TW'($urandom);
    if ($urandom_range(0, 7) == 0) xre_s[u] = 25'sh1000000;
    if ($urandom_range(0, 7) == 0) xim_s[u] = 25'sh0FFFFFF;
    if ($urandom_range(0, 7) == 0) wre_s[u] = 10'sh200;
  endtask

  task automatic test_random(input int u);
    localparam int N = 1000;
    logic signed [DW-1:0] e_re[$], e_im[$];
    logic e_ovf[$];
    logic [NL-1:0] e_ctr[$];
    logic signed [DW-1:0] g_re, g_im, x_re, x_im;
    logic g_ovf, acc;
    logic [NL-1:0] g_ctr;
    int sent, got, cyc;
    sent = 0;
    got = 0;
    cyc = 0;
    @(negedge clk);
    new_sample(u, sent);
    while (got < N && cyc < 20000) begin
      acc = valid_s[u] && ready_s[u];
      @(negedge clk);
      cyc++;
      if (acc) begin
        golden(xre_s[u], xim_s[u], wre_s[u], wim_s[u], g_re, g_im, g_ovf);
        e_re.push_back(g_re);
        e_im.push_back(g_im);
        e_ovf.push_back(g_ovf);
        e_ctr.push_back(ctr_s[u]);
        sent++;
      end
      if (vo_s[u] === 1'b1) begin
        got++;
        n_checks++;
        if (e_re.size() == 0) begin
          n_fail++;
          $display("FAIL rand_spurious u%0d: output ctr=%0d with nothing pending", u, ctro_s[u]);
        end else begin
          x_re = e_re.pop_front();
          x_im = e_im.pop_front();
          g_ovf = e_ovf.pop_front();
          g_ctr = e_ctr.pop_front();
          if (zre_s[u] !== x_re || zim_s[u] !== x_im || ovf_s[u] !== g_ovf || ctro_s[u] !== g_ctr) begin
            n_fail++;
            $display("FAIL rand_sample u%0d ctr %0d: got (%0d,%0d) ovf=%b ctr=%0d want (%0d,%0d) ovf=%b ctr=%0d",
                     u, g_ctr, zre_s[u], zim_s[u], ovf_s[u], ctro_s[u], x_re, x_im, g_ovf, g_ctr);
          end
        end
      end
      if (acc || !valid_s[u]) begin
        if (sent < N) new_sample(u, sent);
        else valid_s[u] = 1'b0;
      end
    end
    n_checks++;
    if (got < N) begin
      n_fail++;
      $display("FAIL rand_timeout u%0d: got %0d outputs want %0d", u, got, N);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rstn_s[u] = 1'b0;
      valid_s[u] = 1'b0;
      ctr_s[u] = '0;
      xre_s[u] = '0;
      xim_s[u] = '0;
      wre_s[u] = '0;
      wim_s[u] = '0;
    end
    repeat (3) @(posedge clk);
    for (int u = 0; u < 2; u++) begin
      test_reset(u);
      test_basic(u);
      test_rounding(u);
      test_saturation(u);
      test_back_to_back(u);
      test_reset_midop(u);
      test_random(u);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
